// File: rtl/game_timer_pkg.sv
// game_timer_pkg: shared run-state encoding and BCD digit constants for the game timer
package game_timer_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    PAUSED  = 2'b10,
    EXPIRED = 2'b11
  } state_e;
  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;
endpackage

// File: rtl/game_timer_counter_bcd_digit_cell.sv
// bcd_digit_cell: one BCD digit bounded by MAX with saturating preset and carry/borrow out
module bcd_digit_cell
  import game_timer_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] MAX = BCD_MAX
) (
  input  logic               clk_1H,
  input  logic               reset,
  input  logic               clr,
  input  logic               ld,
  input  logic [DIGIT_W-1:0] ld_val,
  input  logic               en,
  input  logic               dir,
  output logic [DIGIT_W-1:0] q,
  output logic [DIGIT_W-1:0] nx,
  output logic               co,
  output logic               is_max,
  output logic               is_zero
);
  logic [DIGIT_W-1:0] q_q, q_d, step, ld_sat;
  always_comb begin
    is_max  = q_q == MAX;
    is_zero = q_q == '0;
    ld_sat  = ld_val > MAX ? MAX : ld_val;
    step    = dir ? (is_zero ? MAX : q_q - 4'd1) : (is_max ? '0 : q_q + 4'd1);
    q_d     = clr ? '0 : ld ? ld_sat : en ? step : q_q;
    co      = en & (dir ? is_zero : is_max);
  end
  always_ff @(posedge clk_1H or posedge reset) begin
    if (reset) q_q <= '0;
    else q_q <= q_d;
  end
  assign q  = q_q;
  assign nx = q_d;
endmodule

// File: rtl/game_timer_counter.sv
// game_timer_counter: multi-digit BCD up/down timer with run-state FSM; GAME_TIMER_BLINK_EN adds an expiry blink
module game_timer_counter
  import game_timer_pkg::*;
#(
  parameter int DIGITS  = 2,
  parameter int MSD_MAX = 5
) (
  input  logic                    clk_1H,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    pause,
  input  logic                    clear,
  input  logic                    load,
  input  logic [DIGIT_W*DIGITS-1:0] load_value,
  input  logic                    dir,
  output logic [DIGIT_W*DIGITS-1:0] count_out,
  output logic                    running,
  output logic                    expired,
  output logic                    blink
);
  localparam int W = DIGIT_W * DIGITS;
  state_e state_q, state_d;
  logic [DIGITS:0] en;
  logic [DIGITS-1:0] co, is_max, is_zero;
  logic [W-1:0] nx, max_val;
  logic at_lim, nx_lim;
  // counting is blocked at the limit so the count never wraps
  assign at_lim = dir ? &is_zero : &is_max;
  assign en[0]  = ~clear & ~load & (state_q == RUN) & ~pause & ~at_lim;
  assign nx_lim = (dir ? nx == '0 : nx == max_val) | en[DIGITS];
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    localparam logic [DIGIT_W-1:0] DMAX = (i == DIGITS - 1) ? DIGIT_W'(MSD_MAX) : BCD_MAX;
    assign max_val[DIGIT_W*i +: DIGIT_W] = DMAX;
    bcd_digit_cell #(.MAX(DMAX)) u_cell (
      .clk_1H  (clk_1H),
      .reset   (reset),
      .clr     (clear),
      .ld      (load),
      .ld_val  (load_value[DIGIT_W*i +: DIGIT_W]),
      .en      (en[i]),
      .dir     (dir),
      .q       (count_out[DIGIT_W*i +: DIGIT_W]),
      .nx      (nx[DIGIT_W*i +: DIGIT_W]),
      .co      (co[i]),
      .is_max  (is_max[i]),
      .is_zero (is_zero[i])
    );
    assign en[i+1] = co[i];
  end
  always_ff @(posedge clk_1H or posedge reset) begin
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    unique case (state_q)
      IDLE:    state_d = start ? RUN : IDLE;
      RUN:     state_d = pause ? PAUSED : nx_lim ? EXPIRED : RUN;
      PAUSED:  state_d = start ? RUN : PAUSED;
      default: state_d = EXPIRED;
    endcase
    if (clear | load) state_d = IDLE;
  end
`ifdef GAME_TIMER_BLINK_EN
  logic blink_q, blink_d;
  always_ff @(posedge clk_1H or posedge reset) begin
    if (reset) blink_q <= 1'b0;
    else blink_q <= blink_d;
  end
`endif
  always_comb begin
    running = state_q == RUN;
    expired = state_q == EXPIRED;
`ifdef GAME_TIMER_BLINK_EN
    blink_d = (state_d == EXPIRED) ? ((state_q == EXPIRED) ? ~blink_q : 1'b1) : 1'b0;
    blink   = blink_q;
`else
    blink   = 1'b0;
`endif
  end
endmodule

// File: tb/tb_game_timer_counter.sv
// tb_game_timer_counter: directed stimulus with a queued scoreboard checked by an independent monitor
module tb_game_timer_counter;
  logic clk_1H = 1'b0, reset = 1'b1;
  logic start = 1'b0, pause = 1'b0, clear = 1'b0, load = 1'b0, dir = 1'b0;
  logic [7:0] load_value = 8'h00;
  logic [7:0] count_out;
  logic running, expired, blink;
  always #5 clk_1H = ~clk_1H;
  game_timer_counter #(.DIGITS(2), .MSD_MAX(5)) dut (
    .clk_1H(clk_1H), .reset(reset), .start(start), .pause(pause), .clear(clear),
    .load(load), .load_value(load_value), .dir(dir),
    .count_out(count_out), .running(running), .expired(expired), .blink(blink)
  );
`ifdef GAME_TIMER_BLINK_EN
  localparam logic BL = 1'b1;
`else
  localparam logic BL = 1'b0;
`endif
  typedef struct {
    string      nm;
    logic [7:0] c;
    logic       r;
    logic       e;
    logic       b;
  } exp_t;
  exp_t sb[$];
  int total = 0, bad = 0;
  event chk;
  task automatic step(input string nm, input logic [7:0] c, input logic r, input logic e, input logic b);
    @(posedge clk_1H);
    sb.push_back('{nm, c, r, e, b & BL});
    @(negedge clk_1H);
  endtask
  task automatic check_now(input string nm, input logic [7:0] c, input logic r, input logic e, input logic b);
    sb.push_back('{nm, c, r, e, b & BL});
    ->chk;
  endtask
  initial begin
    exp_t t;
    forever begin
      @(negedge clk_1H or chk);
      if (sb.size() > 0) begin
        t = sb.pop_front();
        total++;
        if ({count_out, running, expired, blink} !== {t.c, t.r, t.e, t.b}) begin
          bad++;
          $display("FAIL %s: got cnt=%h run=%b exp=%b blink=%b, want cnt=%h run=%b exp=%b blink=%b",
                   t.nm, count_out, running, expired, blink, t.c, t.r, t.e, t.b);
        end
      end
    end
  end
  initial begin
    #2 check_now("reset", 8'h00, 0, 0, 0);
    @(negedge clk_1H);
    reset = 1'b0;
    dir = 1'b0; start = 1'b1;
    step("t1_start", 8'h00, 1, 0, 0);
    start = 1'b0;
    for (int i = 1; i <= 12; i++) step("t1_up", 8'((i / 10) * 16 + i % 10), 1, 0, 0);
    load = 1'b1; load_value = 8'h57;
    step("t2_load", 8'h57, 0, 0, 0);
    load = 1'b0; start = 1'b1;
    step("t2_start", 8'h57, 1, 0, 0);
    start = 1'b0;
    step("t2_58", 8'h58, 1, 0, 0);
    step("t2_expire", 8'h59, 0, 1, 1);
    start = 1'b1;
    step("t2_hold_start", 8'h59, 0, 1, 0);
    start = 1'b0; pause = 1'b1;
    step("t2_hold_pause", 8'h59, 0, 1, 1);
    pause = 1'b0;
    step("t2_hold", 8'h59, 0, 1, 0);
    clear = 1'b1;
    step("t3_clear", 8'h00, 0, 0, 0);
    clear = 1'b0; load = 1'b1; load_value = 8'h10; dir = 1'b1;
    step("t3_load", 8'h10, 0, 0, 0);
    load = 1'b0; start = 1'b1;
    step("t3_start", 8'h10, 1, 0, 0);
    start = 1'b0;
    for (int i = 9; i >= 1; i--) step("t3_down", 8'(i), 1, 0, 0);
    step("t3_expire", 8'h00, 0, 1, 1);
    step("t3_hold", 8'h00, 0, 1, 0);
    clear = 1'b1;
    step("bd_clear", 8'h00, 0, 0, 0);
    clear = 1'b0; start = 1'b1;
    step("bd_zero_start", 8'h00, 1, 0, 0);
    start = 1'b0;
    step("bd_zero_expire", 8'h00, 0, 1, 1);
    load = 1'b1; load_value = 8'h59; dir = 1'b0;
    step("bd_max_load", 8'h59, 0, 0, 0);
    load = 1'b0; start = 1'b1;
    step("bd_max_start", 8'h59, 1, 0, 0);
    start = 1'b0;
    step("bd_max_expire", 8'h59, 0, 1, 1);
    clear = 1'b1;
    step("t4_clear", 8'h00, 0, 0, 0);
    clear = 1'b0; start = 1'b1;
    step("t4_start", 8'h00, 1, 0, 0);
    start = 1'b0;
    for (int i = 1; i <= 5; i++) step("t4_up", 8'(i), 1, 0, 0);
    pause = 1'b1;
    for (int i = 0; i < 3; i++) step("t4_paused", 8'h05, 0, 0, 0);
    pause = 1'b0; start = 1'b1;
    step("t4_resume", 8'h05, 1, 0, 0);
    start = 1'b0;
    step("t4_after_resume", 8'h06, 1, 0, 0);
    pause = 1'b1; start = 1'b1;
    step("t4_run_pause_wins", 8'h06, 0, 0, 0);
    step("t4_paused_start_wins", 8'h06, 1, 0, 0);
    pause = 1'b0; start = 1'b0; dir = 1'b1;
    step("t4_dir_down", 8'h05, 1, 0, 0);
    dir = 1'b0;
    step("t4_dir_up", 8'h06, 1, 0, 0);
    load = 1'b1; load_value = 8'h7C;
    step("t5_sat_both", 8'h59, 0, 0, 0);
    load_value = 8'h3A;
    step("t5_sat_lsd", 8'h39, 0, 0, 0);
    clear = 1'b1; load_value = 8'h33;
    step("t5_clear_over_load", 8'h00, 0, 0, 0);
    clear = 1'b0; load_value = 8'h21; start = 1'b1;
    step("t5_load_over_start", 8'h21, 0, 0, 0);
    load = 1'b0;
    step("t5_start_after_load", 8'h21, 1, 0, 0);
    start = 1'b0; clear = 1'b1;
    step("t6_clear", 8'h00, 0, 0, 0);
    clear = 1'b0; start = 1'b1;
    step("t6_start", 8'h00, 1, 0, 0);
    start = 1'b0;
    for (int i = 1; i <= 17; i++) step("t6_up", 8'((i / 10) * 16 + i % 10), 1, 0, 0);
    #2 reset = 1'b1;
    #1 check_now("t6_async_reset", 8'h00, 0, 0, 0);
    step("t6_reset_held", 8'h00, 0, 0, 0);
    reset = 1'b0; start = 1'b1;
    step("t6_restart", 8'h00, 1, 0, 0);
    start = 1'b0;
    step("t6_count", 8'h01, 1, 0, 0);
    repeat (2) @(negedge clk_1H);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
